// File: rtl/load_store_unit_if.sv
// Bus bundle between the execute stage, the load/store unit and the word-wide data memory.
// The unit itself uses the slave view; the core/memory side uses the master view.
interface load_store_unit_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;

  logic [DM_ADDRESS-3:0] mem_addr;
  logic                  mem_re;
  logic [3:0]            mem_we;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  rsp_valid;
  logic                  rsp_err;
  logic [DATA_W-1:0]     rsp_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, mem_addr, mem_re, mem_we, mem_wdata, rsp_valid, rsp_err, rsp_rdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, mem_addr, mem_re, mem_we, mem_wdata, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests (misaligned included) into one or two
// word accesses with byte enables, then merges and extends load data.
module load_store_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave bus
);
  localparam int WORD_W = DM_ADDRESS - 2;

  typedef enum logic [1:0] {S_IDLE, S_A0, S_A1, S_RSP} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_we;
  logic                  r_err;
  logic [2:0]            r_funct3;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_first;

  logic                  w_accept;
  logic                  w_f3_ok;
  logic [1:0]            w_off;
  logic [WORD_W-1:0]     w_word;
  logic [3:0]            w_size_mask;
  logic [7:0]            w_byte_mask;
  logic                  w_split;
  logic [3:0]            w_lane_we;
  logic [2*DATA_W-1:0]   w_wdata_wide;
  logic [2*DATA_W-1:0]   w_pair;
  logic [DATA_W-1:0]     w_shifted;
  logic [DATA_W-1:0]     w_load_result;

  assign w_accept = bus.req_valid && (r_state == S_IDLE) && !reset;

  always_comb begin
    w_f3_ok = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = ~bus.req_we;
      default:                w_f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_size_mask = 4'b1111;
    case (r_funct3[1:0])
      2'b00:   w_size_mask = 4'b0001;
      2'b01:   w_size_mask = 4'b0011;
      default: w_size_mask = 4'b1111;
    endcase
  end

  // Byte mask over two consecutive words; anything landing in the upper nibble is the split part.
  assign w_off        = r_addr[1:0];
  assign w_word       = r_addr[DM_ADDRESS-1:2];
  assign w_byte_mask  = {4'b0000, w_size_mask} << w_off;
  assign w_split      = |w_byte_mask[7:4];
  assign w_wdata_wide = {{DATA_W{1'b0}}, r_wdata} << {w_off, 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_we[gi] = r_we & (((r_state == S_A0) & w_byte_mask[gi]) |
                                     ((r_state == S_A1) & w_byte_mask[gi+4]));
    end
  endgenerate

  // In RSP the memory presents the last word read; for split loads the first word was captured in A1.
  assign w_pair    = {bus.mem_rdata, (w_split ? r_first : bus.mem_rdata)};
  assign w_shifted = DATA_W'(w_pair >> {w_off, 3'b000});

  always_comb begin
    w_load_result = w_shifted;
    case (r_funct3)
      3'b000:  w_load_result = {{(DATA_W-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_result = {{(DATA_W-8){1'b0}}, w_shifted[7:0]};
      3'b001:  w_load_result = {{(DATA_W-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_result = {{(DATA_W-16){1'b0}}, w_shifted[15:0]};
      default: w_load_result = w_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = w_f3_ok ? S_A0 : S_RSP;
      S_A0:   w_state_next = w_split ? S_A1 : S_RSP;
      S_A1:   w_state_next = S_RSP;
      S_RSP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_first  <= '0;
    end else begin
      if (w_accept) begin
        r_we     <= bus.req_we;
        r_err    <= ~w_f3_ok;
        r_funct3 <= bus.req_funct3;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
      end
      if (r_state == S_A1) begin
        r_first <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    bus.req_ready = (r_state == S_IDLE) && !reset;
    bus.mem_addr  = '0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 4'b0000;
    bus.mem_wdata = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = '0;
    case (r_state)
      S_A0: begin
        bus.mem_addr  = w_word;
        bus.mem_re    = ~r_we;
        bus.mem_we    = w_lane_we;
        bus.mem_wdata = r_we ? w_wdata_wide[DATA_W-1:0] : '0;
      end
      S_A1: begin
        bus.mem_addr  = w_word + {{(WORD_W-1){1'b0}}, 1'b1};
        bus.mem_re    = ~r_we;
        bus.mem_we    = w_lane_we;
        bus.mem_wdata = r_we ? w_wdata_wide[2*DATA_W-1:DATA_W] : '0;
      end
      S_RSP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = r_err;
        bus.rsp_rdata = (r_we || r_err) ? '0 : w_load_result;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory behind the unit, byte-level reference model,
// directed cases from the test plan followed by random traffic.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Data memory with one-cycle read latency plus a preload port.
  logic [31:0] mem [128];
  logic        tb_wr;
  logic [6:0]  tb_wa;
  logic [31:0] tb_wd;

  always @(posedge clk) begin
    if (tb_wr) mem[tb_wa] <= tb_wd;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    for (int b = 0; b < 4; b++)
      if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
  end

  logic [7:0]  ref_mem [512];
  int          vectors;
  int          miscompares;
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] val);
    tb_wr = 1'b1;
    tb_wa = 7'(idx);
    tb_wd = val;
    for (int k = 0; k < 4; k++) ref_mem[idx*4 + k] = val[8*k +: 8];
    @(negedge clk);
    tb_wr = 1'b0;
  endtask

  // One request from an idle negedge; checks timing, strobes and response against the model.
  task automatic do_req(input bit we, input bit [2:0] f3, input bit [8:0] addr,
                        input bit [31:0] wd, input string name);
    int          s;
    int          o;
    int          lat;
    int          n_acc;
    int          w;
    bit          ok;
    bit          split;
    logic [31:0] exp_rd;
    logic [63:0] wide;
    logic [3:0]  exp_we [2];
    logic [6:0]  exp_addr [2];
    logic [31:0] exp_wd [2];
    logic [6:0]  obs_addr [8];
    logic        obs_re [8];
    logic [3:0]  obs_we [8];
    logic [31:0] obs_wd [8];

    s      = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    o      = int'(addr[1:0]);
    ok     = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
             (!we && (f3 == 3'b100 || f3 == 3'b101));
    split  = ok && (o + s > 4);
    n_acc  = !ok ? 0 : (split ? 2 : 1);
    exp_rd = 32'h0;
    exp_we[0] = 4'b0; exp_we[1] = 4'b0;
    for (int j = 0; j < 2; j++) exp_addr[j] = 7'(((int'(addr) >> 2) + j) % 128);
    wide      = {32'h0, wd} << (8*o);
    exp_wd[0] = wide[31:0];
    exp_wd[1] = wd >> (8*(4-o));
    for (int k = 0; k < s; k++) begin
      int bu;
      int j;
      bu = int'(addr) + k;
      j  = (bu >> 2) - (int'(addr) >> 2);
      exp_we[j][bu % 4] = 1'b1;
    end
    if (ok && !we) begin
      for (int k = 0; k < s; k++) exp_rd[8*k +: 8] = ref_mem[(int'(addr) + k) % 512];
      if (!f3[2] && s == 1) exp_rd = {{24{exp_rd[7]}}, exp_rd[7:0]};
      if (!f3[2] && s == 2) exp_rd = {{16{exp_rd[15]}}, exp_rd[15:0]};
    end
    if (ok && we)
      for (int k = 0; k < s; k++) ref_mem[(int'(addr) + k) % 512] = wd[8*k +: 8];

    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_ready"}, 32'(bus.req_ready), 32'd1);

    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = 9'($urandom);
    bus.req_wdata = $urandom;

    lat = 0;
    for (int c = 1; c < 7; c++) begin
      if (bus.rsp_valid) begin
        lat = c;
        break;
      end
      obs_addr[c] = bus.mem_addr;
      obs_re[c]   = bus.mem_re;
      obs_we[c]   = bus.mem_we;
      obs_wd[c]   = bus.mem_wdata;
      chk({name, "_busy_ready"}, 32'(bus.req_ready), 32'd0);
      chk({name, "_busy_rdata"}, bus.rsp_rdata, 32'h0);
      @(negedge clk);
    end
    chk({name, "_latency"}, 32'(lat), 32'(!ok ? 1 : (split ? 3 : 2)));
    chk({name, "_err"}, 32'(bus.rsp_err), 32'(!ok));
    chk({name, "_rdata"}, bus.rsp_rdata, exp_rd);
    chk({name, "_rsp_strobes"}, {27'h0, bus.mem_re, bus.mem_we}, 32'h0);
    last_rdata = bus.rsp_rdata;
    if (lat > n_acc) begin
      for (int j = 0; j < n_acc; j++) begin
        chk($sformatf("%s_acc%0d_addr", name, j), 32'(obs_addr[j+1]), 32'(exp_addr[j]));
        chk($sformatf("%s_acc%0d_re", name, j), 32'(obs_re[j+1]), 32'(!we));
        chk($sformatf("%s_acc%0d_we", name, j), 32'(obs_we[j+1]), 32'(we ? exp_we[j] : 4'b0));
        if (we) chk($sformatf("%s_acc%0d_wdata", name, j), obs_wd[j+1], exp_wd[j]);
      end
    end
    @(negedge clk);
    chk({name, "_ready_after"}, 32'(bus.req_ready), 32'd1);
    $display("txn %-10s we=%0d f3=%0d addr=%h wdata=%h -> lat=%0d err=%0d rdata=%h",
             name, we, f3, addr, wd, lat, !ok, last_rdata);
  endtask

  bit [2:0]  load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  bit [2:0]  bad_f3  [3] = '{3'd3, 3'd6, 3'd7};

  initial begin
    bit          we;
    bit [2:0]    f3;
    bit [31:0]   wd;
    logic [31:0] rst_wd;

    vectors        = 0;
    miscompares    = 0;
    tb_wr          = 1'b0;
    tb_wa          = '0;
    tb_wd          = '0;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_rdata  = '0;

    @(negedge clk);
    for (int i = 0; i < 128; i++) set_word(i, $urandom);
    chk("reset_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_strobes", {27'h0, bus.mem_re, bus.mem_we}, 32'h0);
    chk("reset_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    set_word(4, 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 9'h010, 32'h0, "lw_al");
    chk("tp_lw_aligned", last_rdata, 32'hDEADBEEF);

    set_word(4, 32'h80FF0011);
    do_req(1'b0, 3'b000, 9'h013, 32'h0, "lb");
    chk("tp_lb", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 3'b100, 9'h013, 32'h0, "lbu");
    chk("tp_lbu", last_rdata, 32'h00000080);
    do_req(1'b0, 3'b001, 9'h012, 32'h0, "lh");
    chk("tp_lh", last_rdata, 32'hFFFF80FF);
    do_req(1'b0, 3'b101, 9'h010, 32'h0, "lhu");
    chk("tp_lhu", last_rdata, 32'h00000011);

    set_word(3, 32'h44332211);
    set_word(4, 32'h88776655);
    do_req(1'b0, 3'b010, 9'h00E, 32'h0, "lw_mis");
    chk("tp_lw_misaligned", last_rdata, 32'h66554433);

    do_req(1'b1, 3'b001, 9'h007, 32'h0000BEEF, "sh_mis");
    do_req(1'b0, 3'b010, 9'h004, 32'h0, "lw_w1");
    chk("tp_sh_word1_top", {24'h0, last_rdata[31:24]}, 32'hEF);
    do_req(1'b0, 3'b100, 9'h008, 32'h0, "lbu_w2");
    chk("tp_sh_word2_low", last_rdata, 32'hBE);

    do_req(1'b1, 3'b010, 9'h1FE, 32'hAABBCCDD, "sw_wrap");
    do_req(1'b0, 3'b010, 9'h1FE, 32'h0, "lw_wrap");
    chk("tp_wrap_readback", last_rdata, 32'hAABBCCDD);

    do_req(1'b0, 3'b011, 9'h010, 32'h0, "err_ld");
    do_req(1'b1, 3'b100, 9'h020, 32'h12345678, "err_st");

    // Split SW abandoned by reset during its first access: the A0 write lands, nothing else.
    rst_wd         = $urandom;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 9'h0F5;
    bus.req_wdata  = rst_wd;
    for (int k = 0; k < 3; k++) ref_mem[9'h0F5 + k] = rst_wd[8*k +: 8];
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst_a0_we", 32'(bus.mem_we), 32'h0000000E);
    chk("rst_a0_addr", 32'(bus.mem_addr), 32'h3D);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_no_a1", {27'h0, bus.mem_re, bus.mem_we}, 32'h0);
    chk("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("rst_ready_low", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready_high", 32'(bus.req_ready), 32'd1);
    chk("rst_still_no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("rst_still_no_strobe", {27'h0, bus.mem_re, bus.mem_we}, 32'h0);
    $display("txn rst_abort  SW addr=0f5 wdata=%h abandoned after first access", rst_wd);

    for (int i = 0; i < 250; i++) begin
      we = 1'($urandom);
      wd = $urandom;
      if ($urandom_range(0, 15) == 0)
        f3 = we ? 3'($urandom_range(3, 7)) : bad_f3[$urandom_range(0, 2)];
      else
        f3 = we ? 3'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 4)];
      do_req(we, f3, 9'($urandom_range(0, 511)), wd, $sformatf("rnd%0d", i));
    end

    for (int i = 0; i < 128; i++)
      chk($sformatf("final_word%0d", i), mem[i],
          {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
